// File: rtl/mem_req_scheduler_pkg.sv
// Shared types for the memory request scheduler: bus commands, access sizes,
// and the requester identity stored in the tag owner table.
package mem_req_scheduler_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic {
        REQ_DCACHE = 1'b0,
        REQ_ICACHE = 1'b1
    } MEM_REQUESTER;

    // A requester is active whenever it drives anything other than BUS_NONE.
    function automatic logic bus_active(input BUS_COMMAND cmd);
        return cmd != BUS_NONE;
    endfunction

endpackage

// File: rtl/mem_tag_owner_table.sv
// Tag owner table: one {valid, owner} entry per memory tag. A lookup reads the
// current (pre-edge) state so a same-cycle return sees the old owner; the
// clear from that return is applied before the allocation, so a same-tag
// allocation in the same cycle survives.
module mem_tag_owner_table
    import mem_req_scheduler_pkg::*;
#(
    parameter int NUM_TAGS = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        alloc_en,
    input  logic [$clog2(NUM_TAGS)-1:0] alloc_tag,
    input  MEM_REQUESTER                alloc_owner,
    input  logic [$clog2(NUM_TAGS)-1:0] lookup_tag,
    output logic                        lookup_valid,
    output MEM_REQUESTER                lookup_owner,
    output logic                        orphan_err,
    output logic                        overwrite_err
);

    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [NUM_TAGS-1:0] owner_q, owner_d;
    logic                ret_req;

    // Lookup, error strobes and next-state of the table.
    always_comb begin
        valid_d       = valid_q;
        owner_d       = owner_q;
        ret_req       = lookup_tag != '0;
        lookup_valid  = ret_req && valid_q[lookup_tag];
        lookup_owner  = MEM_REQUESTER'(owner_q[lookup_tag]);
        orphan_err    = ret_req && !valid_q[lookup_tag];
        // A slot being released by a return this cycle is not an overwrite.
        overwrite_err = alloc_en && valid_q[alloc_tag] &&
                        !(ret_req && (lookup_tag == alloc_tag));
        if (ret_req) begin
            valid_d[lookup_tag] = 1'b0;
        end
        if (alloc_en) begin
            valid_d[alloc_tag] = 1'b1;
            owner_d[alloc_tag] = alloc_owner;
        end
    end

    // Table state register; reset discards all ownership.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            owner_q <= '0;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: rtl/mem_req_scheduler.sv
// Memory request scheduler: arbitrates the single memory bus between Dcache
// (priority) and Icache (anti-starvation forced grant), tracks tag ownership
// and routes tagged returns to the issuing cache.
// Optional feature macro: MEM_SCHED_STATS_EN adds saturating grant/reject
// statistics counters.
module mem_req_scheduler
    import mem_req_scheduler_pkg::*;
#(
    parameter int NUM_TAGS     = 16,
    parameter int STARVE_LIMIT = 8
`ifdef MEM_SCHED_STATS_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic                        clock,
    input  logic                        reset,
    input  BUS_COMMAND                  Dcache2mem_command,
    input  MEM_SIZE                     Dcache2mem_size,
    input  logic [XLEN-1:0]             Dcache2mem_addr,
    input  logic [XLEN-1:0]             Dcache2mem_data,
    input  BUS_COMMAND                  Icache2mem_command,
    input  logic [XLEN-1:0]             Icache2mem_addr,
    input  logic [$clog2(NUM_TAGS)-1:0] mem2cache_response,
    input  logic [63:0]                 mem2cache_data,
    input  logic [$clog2(NUM_TAGS)-1:0] mem2cache_tag,
    output BUS_COMMAND                  cache2mem_command,
    output MEM_SIZE                     cache2mem_size,
    output logic [XLEN-1:0]             cache2mem_addr,
    output logic [XLEN-1:0]             cache2mem_data,
    output logic [$clog2(NUM_TAGS)-1:0] mem2Dcache_response,
    output logic [63:0]                 mem2Dcache_data,
    output logic [$clog2(NUM_TAGS)-1:0] mem2Dcache_tag,
    output logic [$clog2(NUM_TAGS)-1:0] mem2Icache_response,
    output logic [63:0]                 mem2Icache_data,
    output logic [$clog2(NUM_TAGS)-1:0] mem2Icache_tag,
    output logic [$clog2(NUM_TAGS):0]   d_outstanding,
    output logic [$clog2(NUM_TAGS):0]   i_outstanding,
    output logic                        sched_err
`ifdef MEM_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]            stat_d_grants,
    output logic [CNT_W-1:0]            stat_i_grants,
    output logic [CNT_W-1:0]            stat_i_forced,
    output logic [CNT_W-1:0]            stat_rejects
`endif
);

    localparam int OUT_W    = $clog2(NUM_TAGS) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
    logic [OUT_W-1:0]    d_out_q, d_out_d;
    logic [OUT_W-1:0]    i_out_q, i_out_d;
    logic                err_q, err_d;

    logic         d_act, i_act, force_i, grant_d, grant_i, accepted;
    logic         alloc_en;
    MEM_REQUESTER alloc_owner;
    logic         lookup_valid, orphan_err, overwrite_err;
    MEM_REQUESTER lookup_owner;
    logic         d_inc, d_dec, i_inc, i_dec;

    // Zero-latency grant and bus mux; Icache wins only when forced or Dcache idle.
    always_comb begin
        d_act               = bus_active(Dcache2mem_command);
        i_act               = bus_active(Icache2mem_command);
        force_i             = starve_cnt_q >= STARVE_W'(STARVE_LIMIT);
        grant_i             = i_act && (force_i || !d_act);
        grant_d             = d_act && !grant_i;
        cache2mem_command   = BUS_NONE;
        cache2mem_size      = BYTE;
        cache2mem_addr      = '0;
        cache2mem_data      = '0;
        if (grant_d) begin
            cache2mem_command = Dcache2mem_command;
            cache2mem_size    = Dcache2mem_size;
            cache2mem_addr    = Dcache2mem_addr;
            cache2mem_data    = Dcache2mem_data;
        end else if (grant_i) begin
            cache2mem_command = Icache2mem_command;
            cache2mem_size    = DOUBLE;
            cache2mem_addr    = Icache2mem_addr;
        end
        accepted            = (grant_d || grant_i) && (mem2cache_response != '0);
        alloc_en            = accepted && (cache2mem_command == BUS_LOAD);
        alloc_owner         = grant_i ? REQ_ICACHE : REQ_DCACHE;
        mem2Dcache_response = grant_d ? mem2cache_response : '0;
        mem2Icache_response = grant_i ? mem2cache_response : '0;
    end

    mem_tag_owner_table #(
        .NUM_TAGS(NUM_TAGS)
    ) u_owner_table (
        .clock        (clock),
        .reset        (reset),
        .alloc_en     (alloc_en),
        .alloc_tag    (mem2cache_response),
        .alloc_owner  (alloc_owner),
        .lookup_tag   (mem2cache_tag),
        .lookup_valid (lookup_valid),
        .lookup_owner (lookup_owner),
        .orphan_err   (orphan_err),
        .overwrite_err(overwrite_err)
    );

    // Return routing: only the owning cache sees the tag; orphans go nowhere.
    always_comb begin
        mem2Dcache_data = mem2cache_data;
        mem2Icache_data = mem2cache_data;
        mem2Dcache_tag  = (lookup_valid && lookup_owner == REQ_DCACHE) ? mem2cache_tag : '0;
        mem2Icache_tag  = (lookup_valid && lookup_owner == REQ_ICACHE) ? mem2cache_tag : '0;
    end

    // Next-state for starvation counter, outstanding counters and error flag.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_act || (grant_i && accepted)) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < STARVE_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
        d_inc   = alloc_en && (alloc_owner == REQ_DCACHE);
        i_inc   = alloc_en && (alloc_owner == REQ_ICACHE);
        d_dec   = lookup_valid && (lookup_owner == REQ_DCACHE);
        i_dec   = lookup_valid && (lookup_owner == REQ_ICACHE);
        d_out_d = d_out_q;
        i_out_d = i_out_q;
        if (d_inc && !d_dec) d_out_d = d_out_q + OUT_W'(1);
        if (d_dec && !d_inc) d_out_d = d_out_q - OUT_W'(1);
        if (i_inc && !i_dec) i_out_d = i_out_q + OUT_W'(1);
        if (i_dec && !i_inc) i_out_d = i_out_q - OUT_W'(1);
        err_d = err_q || orphan_err || overwrite_err;
    end

    // Scheduler state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
            d_out_q      <= '0;
            i_out_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            d_out_q      <= d_out_d;
            i_out_q      <= i_out_d;
            err_q        <= err_d;
        end
    end

    assign d_outstanding = d_out_q;
    assign i_outstanding = i_out_q;
    assign sched_err     = err_q;

`ifdef MEM_SCHED_STATS_EN
    logic [CNT_W-1:0] stat_d_q, stat_d_d;
    logic [CNT_W-1:0] stat_i_q, stat_i_d;
    logic [CNT_W-1:0] stat_f_q, stat_f_d;
    logic [CNT_W-1:0] stat_r_q, stat_r_d;

    // Saturating statistics next-state.
    always_comb begin
        stat_d_d = stat_d_q;
        stat_i_d = stat_i_q;
        stat_f_d = stat_f_q;
        stat_r_d = stat_r_q;
        if (accepted && grant_d && stat_d_q != '1) stat_d_d = stat_d_q + CNT_W'(1);
        if (accepted && grant_i && stat_i_q != '1) stat_i_d = stat_i_q + CNT_W'(1);
        if (grant_i && force_i && stat_f_q != '1)  stat_f_d = stat_f_q + CNT_W'(1);
        if ((grant_d || grant_i) && !accepted && stat_r_q != '1) stat_r_d = stat_r_q + CNT_W'(1);
    end

    // Statistics register.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_d_q <= '0;
            stat_i_q <= '0;
            stat_f_q <= '0;
            stat_r_q <= '0;
        end else begin
            stat_d_q <= stat_d_d;
            stat_i_q <= stat_i_d;
            stat_f_q <= stat_f_d;
            stat_r_q <= stat_r_d;
        end
    end

    assign stat_d_grants = stat_d_q;
    assign stat_i_grants = stat_i_q;
    assign stat_i_forced = stat_f_q;
    assign stat_rejects  = stat_r_q;
`endif

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed bench for mem_req_scheduler: arbitration, starvation, tag routing,
// error flag and reset behaviour. Return routing goes through a scoreboard.
module tb_mem_req_scheduler;
    import mem_req_scheduler_pkg::*;

    localparam int NUM_TAGS = 16;
    localparam int TW       = $clog2(NUM_TAGS);
    localparam int OW       = TW + 1;

    logic              clock;
    logic              reset;
    BUS_COMMAND        Dcache2mem_command;
    MEM_SIZE           Dcache2mem_size;
    logic [XLEN-1:0]   Dcache2mem_addr;
    logic [XLEN-1:0]   Dcache2mem_data;
    BUS_COMMAND        Icache2mem_command;
    logic [XLEN-1:0]   Icache2mem_addr;
    logic [TW-1:0]     mem2cache_response;
    logic [63:0]       mem2cache_data;
    logic [TW-1:0]     mem2cache_tag;
    BUS_COMMAND        cache2mem_command;
    MEM_SIZE           cache2mem_size;
    logic [XLEN-1:0]   cache2mem_addr;
    logic [XLEN-1:0]   cache2mem_data;
    logic [TW-1:0]     mem2Dcache_response;
    logic [63:0]       mem2Dcache_data;
    logic [TW-1:0]     mem2Dcache_tag;
    logic [TW-1:0]     mem2Icache_response;
    logic [63:0]       mem2Icache_data;
    logic [TW-1:0]     mem2Icache_tag;
    logic [OW-1:0]     d_outstanding;
    logic [OW-1:0]     i_outstanding;
    logic              sched_err;
`ifdef MEM_SCHED_STATS_EN
    logic [31:0]       stat_d_grants, stat_i_grants, stat_i_forced, stat_rejects;
`endif

    int checks = 0;
    int errors = 0;

    // Expected {Dcache tag, Icache tag} for each driven return.
    logic [2*TW-1:0] exp_q[$];
    // Bench-side ownership model: valid bit and owner (1 = Icache).
    logic            m_valid [NUM_TAGS];
    logic            m_owner [NUM_TAGS];

    mem_req_scheduler #(
        .NUM_TAGS    (NUM_TAGS),
        .STARVE_LIMIT(8)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .Dcache2mem_command (Dcache2mem_command),
        .Dcache2mem_size    (Dcache2mem_size),
        .Dcache2mem_addr    (Dcache2mem_addr),
        .Dcache2mem_data    (Dcache2mem_data),
        .Icache2mem_command (Icache2mem_command),
        .Icache2mem_addr    (Icache2mem_addr),
        .mem2cache_response (mem2cache_response),
        .mem2cache_data     (mem2cache_data),
        .mem2cache_tag      (mem2cache_tag),
        .cache2mem_command  (cache2mem_command),
        .cache2mem_size     (cache2mem_size),
        .cache2mem_addr     (cache2mem_addr),
        .cache2mem_data     (cache2mem_data),
        .mem2Dcache_response(mem2Dcache_response),
        .mem2Dcache_data    (mem2Dcache_data),
        .mem2Dcache_tag     (mem2Dcache_tag),
        .mem2Icache_response(mem2Icache_response),
        .mem2Icache_data    (mem2Icache_data),
        .mem2Icache_tag     (mem2Icache_tag),
        .d_outstanding      (d_outstanding),
        .i_outstanding      (i_outstanding),
        .sched_err          (sched_err)
`ifdef MEM_SCHED_STATS_EN
        ,
        .stat_d_grants      (stat_d_grants),
        .stat_i_grants      (stat_i_grants),
        .stat_i_forced      (stat_i_forced),
        .stat_rejects       (stat_rejects)
`endif
    );

    // Clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        Dcache2mem_command = BUS_NONE;
        Dcache2mem_size    = BYTE;
        Dcache2mem_addr    = '0;
        Dcache2mem_data    = '0;
        Icache2mem_command = BUS_NONE;
        Icache2mem_addr    = '0;
        mem2cache_response = '0;
        mem2cache_data     = '0;
        mem2cache_tag      = '0;
    endtask

    task automatic model_clear();
        for (int t = 0; t < NUM_TAGS; t++) begin
            m_valid[t] = 1'b0;
            m_owner[t] = 1'b0;
        end
    endtask

    task automatic model_alloc(input int t, input logic is_i);
        m_valid[t] = 1'b1;
        m_owner[t] = is_i;
    endtask

    // Drive a return and push its expected routing from the model (old owner).
    task automatic drive_return(input int t, input logic [63:0] data);
        logic [TW-1:0] tg;
        tg             = TW'(t);
        mem2cache_tag  = tg;
        mem2cache_data = data;
        if (!m_valid[t])     exp_q.push_back('0);
        else if (m_owner[t]) exp_q.push_back({{TW{1'b0}}, tg});
        else                 exp_q.push_back({tg, {TW{1'b0}}});
        m_valid[t] = 1'b0;
    endtask

    task automatic check_return(input string tag);
        logic [2*TW-1:0] exp;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {mem2Dcache_tag, mem2Icache_tag}, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        set_idle();
        model_clear();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_d_out", d_outstanding, 0);
        check("rst_i_out", i_outstanding, 0);
        check("rst_err", sched_err, 0);

        @(negedge clock);
        reset = 1'b0;
        #1;
        check("idle_cmd", cache2mem_command, BUS_NONE);
        check("idle_size", cache2mem_size, BYTE);
        check("idle_addr", cache2mem_addr, 0);
        check("idle_data", cache2mem_data, 0);

        // Both caches load together: Dcache wins.
        @(negedge clock);
        set_idle();
        Dcache2mem_command = BUS_LOAD; Dcache2mem_size = WORD; Dcache2mem_addr = 32'h100;
        Icache2mem_command = BUS_LOAD; Icache2mem_addr = 32'h200;
        mem2cache_response = 4'd3;
        model_alloc(3, 1'b0);
        #1;
        check("t1_cmd", cache2mem_command, BUS_LOAD);
        check("t1_addr", cache2mem_addr, 32'h100);
        check("t1_d_resp", mem2Dcache_response, 3);
        check("t1_i_resp", mem2Icache_response, 0);
        tick();
        check("t1_d_out", d_outstanding, 1);
        check("t1_i_out", i_outstanding, 0);

        // Return tag 3 to Dcache.
        @(negedge clock);
        set_idle();
        drive_return(3, 64'hDEAD);
        #1;
        check_return("t2_route");
        check("t2_d_data", mem2Dcache_data, 64'hDEAD);
        check("t2_i_data", mem2Icache_data, 64'hDEAD);
        tick();
        check("t2_d_out", d_outstanding, 0);

        // Starvation: Dcache stores every cycle, Icache load held until forced.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            set_idle();
            Dcache2mem_command = BUS_STORE; Dcache2mem_size = WORD;
            Dcache2mem_addr    = 32'h300 + 32'(i * 8);
            Dcache2mem_data    = 32'(i + 1);
            Icache2mem_command = BUS_LOAD; Icache2mem_addr = 32'h200;
            mem2cache_response = (i == 8) ? 4'd6 : 4'd2;
            #1;
            if (i == 8) begin
                model_alloc(6, 1'b1);
                check("t3_force_cmd", cache2mem_command, BUS_LOAD);
                check("t3_force_addr", cache2mem_addr, 32'h200);
                check("t3_force_size", cache2mem_size, DOUBLE);
                check("t3_force_data", cache2mem_data, 0);
                check("t3_force_i_resp", mem2Icache_response, 6);
                check("t3_force_d_resp", mem2Dcache_response, 0);
            end else begin
                check($sformatf("t3_d_cmd_%0d", i), cache2mem_command, BUS_STORE);
                check($sformatf("t3_d_data_%0d", i), cache2mem_data, 32'(i + 1));
                check($sformatf("t3_d_resp_%0d", i), mem2Dcache_response, 2);
                check($sformatf("t3_i_resp_%0d", i), mem2Icache_response, 0);
            end
        end
        tick();
        check("t3_i_out", i_outstanding, 1);
        check("t3_d_out", d_outstanding, 0);
        check("t3_err", sched_err, 0);

        // Tag 5 owned by Dcache, then re-accepted for Icache while returning.
        @(negedge clock);
        set_idle();
        Dcache2mem_command = BUS_LOAD; Dcache2mem_size = WORD; Dcache2mem_addr = 32'h500;
        mem2cache_response = 4'd5;
        model_alloc(5, 1'b0);
        #1;
        check("t4a_d_resp", mem2Dcache_response, 5);
        tick();
        check("t4a_d_out", d_outstanding, 1);

        @(negedge clock);
        set_idle();
        Icache2mem_command = BUS_LOAD; Icache2mem_addr = 32'h240;
        mem2cache_response = 4'd5;
        drive_return(5, 64'hBEEF);
        model_alloc(5, 1'b1);
        #1;
        check("t4b_i_resp", mem2Icache_response, 5);
        check_return("t4b_route_old");
        tick();
        check("t4b_d_out", d_outstanding, 0);
        check("t4b_i_out", i_outstanding, 2);

        @(negedge clock);
        set_idle();
        drive_return(5, 64'h1234);
        #1;
        check_return("t4c_route_new");
        tick();
        check("t4c_i_out", i_outstanding, 1);

        @(negedge clock);
        set_idle();
        drive_return(6, 64'h5678);
        #1;
        check_return("t4d_route");
        tick();
        check("t4d_i_out", i_outstanding, 0);

        // Orphan return.
        @(negedge clock);
        set_idle();
        drive_return(7, 64'h7777);
        #1;
        check_return("t5_orphan_route");
        tick();
        check("t5_err", sched_err, 1);
        @(negedge clock);
        set_idle();
        tick();
        check("t5_err_held", sched_err, 1);

        // Store accept allocates nothing.
        @(negedge clock);
        set_idle();
        Dcache2mem_command = BUS_STORE; Dcache2mem_addr = 32'h400; Dcache2mem_data = 32'hCAFE;
        mem2cache_response = 4'd4;
        #1;
        check("t6_store_resp", mem2Dcache_response, 4);
        tick();
        check("t6_store_d_out", d_outstanding, 0);

        @(negedge clock);
        set_idle();
        Dcache2mem_command = BUS_LOAD; Dcache2mem_addr = 32'h900;
        Icache2mem_command = BUS_LOAD; Icache2mem_addr = 32'h280;
        mem2cache_response = 4'd9;
        model_alloc(9, 1'b0);
        tick();
        check("t6_d_out", d_outstanding, 1);

        @(negedge clock);
        set_idle();
        Icache2mem_command = BUS_LOAD; Icache2mem_addr = 32'h280;
        mem2cache_response = 4'd10;
        model_alloc(10, 1'b1);
        tick();
        check("t6_i_out", i_outstanding, 1);

        // Reset with loads in flight; combinational path still follows inputs.
        @(negedge clock);
        set_idle();
        reset = 1'b1;
        Dcache2mem_command = BUS_LOAD; Dcache2mem_addr = 32'h700;
        model_clear();
        #1;
        check("t6_rst_comb_addr", cache2mem_addr, 32'h700);
        check("t6_rst_comb_cmd", cache2mem_command, BUS_LOAD);
        tick();
        check("t6_rst_d_out", d_outstanding, 0);
        check("t6_rst_i_out", i_outstanding, 0);
        check("t6_rst_err", sched_err, 0);

        @(negedge clock);
        set_idle();
        reset = 1'b0;
        drive_return(9, 64'h9999);
        #1;
        check_return("t6_orphan_route");
        tick();
        check("t6_orphan_err", sched_err, 1);
        check("t6_orphan_d_out", d_outstanding, 0);

        // Overwrite of a valid entry flags an error.
        @(negedge clock);
        set_idle();
        reset = 1'b1;
        model_clear();
        tick();
        @(negedge clock);
        reset = 1'b0;
        Dcache2mem_command = BUS_LOAD; Dcache2mem_addr = 32'hB00;
        mem2cache_response = 4'd11;
        tick();
        check("t7_first_err", sched_err, 0);
        @(negedge clock);
        Dcache2mem_addr = 32'hB40;
        tick();
        check("t7_overwrite_err", sched_err, 1);
        check("t7_d_out", d_outstanding, 2);

        @(negedge clock);
        set_idle();
        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
